// File: rtl/run_ctrl.sv
// Run controller for the mips32 core: sequences core reset, detects end-of-program, drains, reports done.
// Optional store counter (ports dce/we/stores) is enabled with `define RUN_CTRL_STORE_CNT_EN.
module run_ctrl #(
    parameter int unsigned     AW           = 32,
    parameter logic [AW-1:0]   END_ADDR     = AW'(32'd156),
    parameter int unsigned     RST_CYCLES   = 5,
    parameter int unsigned     DRAIN_CYCLES = 10,
    parameter int unsigned     TIMEOUT      = 100000,
    parameter int unsigned     CW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] iaddr,
    input  logic          ice,
`ifdef RUN_CTRL_STORE_CNT_EN
    input  logic          dce,
    input  logic [3:0]    we,
    output logic [CW-1:0] stores,
`endif
    output logic          core_rst_n,
    output logic          busy,
    output logic          done,
    output logic          timed_out,
    output logic [CW-1:0] cycles,
    output logic [CW-1:0] fetches
);

    localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned DCW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           timed_out_d;
    logic [CW-1:0]  cycles_d, fetches_d;
    logic           core_on;
`ifdef RUN_CTRL_STORE_CNT_EN
    logic [CW-1:0]  stores_d;
`endif

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // Next-state and next-counter logic
    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        dcnt_d      = dcnt_q;
        wdog_d      = wdog_q;
        timed_out_d = timed_out;
        cycles_d    = cycles;
        fetches_d   = fetches;
`ifdef RUN_CTRL_STORE_CNT_EN
        stores_d    = stores;
`endif
        core_on     = (state_q == S_RUN) || (state_q == S_DRAIN);

        if (core_on) begin
            cycles_d = sat_inc(cycles);
            if (ice) begin
                fetches_d = sat_inc(fetches);
            end
`ifdef RUN_CTRL_STORE_CNT_EN
            if (dce && (|we)) begin
                stores_d = sat_inc(stores);
            end
`endif
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RESET;
                    rcnt_d      = RCW'(RST_CYCLES - 1);
                    cycles_d    = '0;
                    fetches_d   = '0;
                    timed_out_d = 1'b0;
`ifdef RUN_CTRL_STORE_CNT_EN
                    stores_d    = '0;
`endif
                end
            end
            S_RESET: begin
                if (rcnt_q == '0) begin
                    state_d = S_RUN;
                    wdog_d  = '0;
                end else begin
                    rcnt_d = rcnt_q - RCW'(1);
                end
            end
            S_RUN: begin
                wdog_d = wdog_q + WDW'(1);
                // An end-address match beats a watchdog expiry in the same cycle
                if (iaddr == END_ADDR) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                        dcnt_d  = DCW'(DRAIN_CYCLES);
                    end
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    state_d     = S_DONE;
                    timed_out_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DCW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    dcnt_d = dcnt_q - DCW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered decodes of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rcnt_q     <= '0;
            dcnt_q     <= '0;
            wdog_q     <= '0;
            timed_out  <= 1'b0;
            cycles     <= '0;
            fetches    <= '0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef RUN_CTRL_STORE_CNT_EN
            stores     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            dcnt_q     <= dcnt_d;
            wdog_q     <= wdog_d;
            timed_out  <= timed_out_d;
            cycles     <= cycles_d;
            fetches    <= fetches_d;
            core_rst_n <= (state_d == S_RUN) || (state_d == S_DRAIN);
            busy       <= (state_d == S_RESET) || (state_d == S_RUN) || (state_d == S_DRAIN);
            done       <= (state_d == S_DONE);
`ifdef RUN_CTRL_STORE_CNT_EN
            stores     <= stores_d;
`endif
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: two instances (drain 10 / drain 0 with a narrow saturating counter)
// driven by shared random address/fetch traces and checked against a run-length model.
module tb_run_ctrl;

    localparam int          RST_N   = 5;
    localparam int          DRAIN_A = 10;
    localparam int          TMO     = 64;
    localparam int          CWB     = 5;
    localparam int          SATB    = 31;
    localparam int          TLEN    = 80;
    localparam logic [31:0] END_A   = 32'd156;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] iaddr;
    logic        ice;

    logic            crn_a, busy_a, done_a, to_a;
    logic [31:0]     cyc_a, fet_a;
    logic            crn_b, busy_b, done_b, to_b;
    logic [CWB-1:0]  cyc_b, fet_b;
`ifdef RUN_CTRL_STORE_CNT_EN
    logic            dce;
    logic [3:0]      we;
    logic [31:0]     st_a;
    logic [CWB-1:0]  st_b;
    logic            dce_t [TLEN];
    logic [3:0]      we_t  [TLEN];
`endif

    logic [31:0] addr_t [TLEN];
    logic        ice_t  [TLEN];
    int          mk;
    int          n_assert;
    int          n_fail;

    run_ctrl #(.AW(32), .END_ADDR(END_A), .RST_CYCLES(RST_N), .DRAIN_CYCLES(DRAIN_A),
               .TIMEOUT(TMO), .CW(32)) u_a (
        .clk(clk), .rst(rst), .start(start), .iaddr(iaddr), .ice(ice),
`ifdef RUN_CTRL_STORE_CNT_EN
        .dce(dce), .we(we), .stores(st_a),
`endif
        .core_rst_n(crn_a), .busy(busy_a), .done(done_a), .timed_out(to_a),
        .cycles(cyc_a), .fetches(fet_a)
    );

    run_ctrl #(.AW(32), .END_ADDR(END_A), .RST_CYCLES(RST_N), .DRAIN_CYCLES(0),
               .TIMEOUT(TMO), .CW(CWB)) u_b (
        .clk(clk), .rst(rst), .start(start), .iaddr(iaddr), .ice(ice),
`ifdef RUN_CTRL_STORE_CNT_EN
        .dce(dce), .we(we), .stores(st_b),
`endif
        .core_rst_n(crn_b), .busy(busy_b), .done(done_b), .timed_out(to_b),
        .cycles(cyc_b), .fetches(fet_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_nonend();
        logic [31:0] v;
        v = 32'($urandom_range(0, 255)) * 32'd4;
        return (v == END_A) ? 32'd0 : v;
    endfunction

    // Fill a trace whose first end-address hit is at RUN cycle m (m >= TMO means no match in time)
    task automatic gen(input int m);
        for (int k = 0; k < TLEN; k++) begin
            addr_t[k] = rand_nonend();
            ice_t[k]  = 1'($urandom % 2);
`ifdef RUN_CTRL_STORE_CNT_EN
            dce_t[k]  = 1'($urandom % 2);
            we_t[k]   = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
`endif
        end
        if (m < TLEN) addr_t[m] = END_A;
        if (m + 1 < TLEN) addr_t[m + 1] = END_A;
        mk = m;
    endtask

    task automatic chk_reset();
        chk("a.core_rst_n", 32'(crn_a), 32'd0);
        chk("a.busy", 32'(busy_a), 32'd0);
        chk("a.done", 32'(done_a), 32'd0);
        chk("a.timed_out", 32'(to_a), 32'd0);
        chk("a.cycles", cyc_a, 32'd0);
        chk("a.fetches", fet_a, 32'd0);
        chk("b.core_rst_n", 32'(crn_b), 32'd0);
        chk("b.busy", 32'(busy_b), 32'd0);
        chk("b.done", 32'(done_b), 32'd0);
        chk("b.timed_out", 32'(to_b), 32'd0);
        chk("b.cycles", 32'(cyc_b), 32'd0);
        chk("b.fetches", 32'(fet_b), 32'd0);
`ifdef RUN_CTRL_STORE_CNT_EN
        chk("a.stores", st_a, 32'd0);
        chk("b.stores", 32'(st_b), 32'd0);
`endif
    endtask

    // Expected outputs of one instance at observation c after start, for a run of len active cycles
    task automatic chk_inst(input string nm, input int c, input int len, input bit tout, input int sat,
                            input logic o_crn, input logic o_busy, input logic o_done,
                            input logic o_to, input logic [31:0] o_cyc, input logic [31:0] o_fet,
                            input logic [31:0] o_st);
        int ran, fet, st;
        ran = c - RST_N;
        if (ran < 0) ran = 0;
        if (ran > len) ran = len;
        fet = 0;
        st  = 0;
        for (int k = 0; k < ran; k++) begin
            fet += int'(ice_t[k]);
`ifdef RUN_CTRL_STORE_CNT_EN
            st += int'(dce_t[k] && (|we_t[k]));
`endif
        end
        chk({nm, ".busy"}, 32'(o_busy), 32'(c < RST_N + len));
        chk({nm, ".core_rst_n"}, 32'(o_crn), 32'(c >= RST_N && c < RST_N + len));
        chk({nm, ".done"}, 32'(o_done), 32'(c >= RST_N + len));
        chk({nm, ".timed_out"}, 32'(o_to), 32'((c >= RST_N + len) && tout));
        chk({nm, ".cycles"}, o_cyc, 32'((ran > sat) ? sat : ran));
        chk({nm, ".fetches"}, o_fet, 32'((fet > sat) ? sat : fet));
`ifdef RUN_CTRL_STORE_CNT_EN
        chk({nm, ".stores"}, o_st, 32'((st > sat) ? sat : st));
`endif
    endtask

    // Start a run on the current trace; optionally pulse rst at observation abort_c
    task automatic run_trace(input int abort_c);
        bit   matched;
        int   runl, len_a, len_b, k;
        logic [31:0] st_oa, st_ob;
        matched = (mk < TMO);
        runl    = matched ? mk + 1 : TMO;
        len_a   = runl + (matched ? DRAIN_A : 0);
        len_b   = runl;
        start   = 1'b1;
        iaddr   = END_A;
        ice     = 1'b1;
`ifdef RUN_CTRL_STORE_CNT_EN
        dce = 1'b1;
        we  = 4'hF;
`endif
        for (int c = 0; c <= RST_N + len_a + 1; c++) begin
            @(negedge clk);
            st_oa = 32'd0;
            st_ob = 32'd0;
`ifdef RUN_CTRL_STORE_CNT_EN
            st_oa = st_a;
            st_ob = 32'(st_b);
`endif
            chk_inst("a", c, len_a, !matched, 32'hFFFF_FFFF >> 1, crn_a, busy_a, done_a, to_a,
                     cyc_a, fet_a, st_oa);
            chk_inst("b", c, len_b, !matched, SATB, crn_b, busy_b, done_b, to_b,
                     32'(cyc_b), 32'(fet_b), st_ob);
            if (c == abort_c) begin
                rst   = 1'b1;
                start = 1'b0;
                @(negedge clk);
                chk_reset();
                rst = 1'b0;
                return;
            end
            k     = c - RST_N;
            start = (c < RST_N + len_b) ? 1'($urandom % 2) : 1'b0;
            iaddr = (k >= 0) ? addr_t[k] : END_A;
            ice   = (k >= 0) ? ice_t[k] : 1'b1;
`ifdef RUN_CTRL_STORE_CNT_EN
            dce = (k >= 0) ? dce_t[k] : 1'b1;
            we  = (k >= 0) ? we_t[k] : 4'hF;
`endif
        end
        start = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        iaddr    = 32'd0;
        ice      = 1'b0;
`ifdef RUN_CTRL_STORE_CNT_EN
        dce = 1'b0;
        we  = 4'h0;
`endif
        repeat (2) @(negedge clk);
        chk_reset();
        rst = 1'b0;

`ifdef RUN_CTRL_STORE_CNT_EN
        // Store-like traffic while idle must not count
        dce = 1'b1;
        we  = 4'hF;
        ice = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle.stores", st_a, 32'd0);
        chk("idle.fetches", fet_a, 32'd0);
        dce = 1'b0;
        we  = 4'h0;
`endif

        // Basic run: fetch address steps by 4 from 0, always fetching
        gen(39);
        for (int k = 0; k < TLEN; k++) begin
            addr_t[k] = 32'(k) * 32'd4;
            ice_t[k]  = 1'b1;
        end
        run_trace(-1);

        // Watchdog: address stuck at 0
        gen(TLEN);
        for (int k = 0; k < TLEN; k++) addr_t[k] = 32'd0;
        run_trace(-1);

        // Match on the last watchdog cycle, then one cycle too late
        gen(TMO - 1);
        run_trace(-1);
        gen(TMO);
        run_trace(-1);

        // Match on the very first RUN cycle
        gen(0);
        run_trace(-1);

        // Synchronous reset while instance a drains, then a fresh start from IDLE
        gen(int'($urandom_range(5, 40)));
        run_trace(RST_N + mk + 4);
        gen(int'($urandom_range(0, 50)));
        run_trace(-1);

        // Random back-to-back runs, some timing out
        for (int r = 0; r < 6; r++) begin
            gen((r % 3 == 2) ? TLEN : int'($urandom_range(0, TMO - 1)));
            run_trace(-1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
